// File: rtl/common_pseudo_lru_alloc_binrd_if.sv
// common_pseudo_lru_alloc_binrd_if: request/response handshake and pLRU port bundle for the allocation controller
interface common_pseudo_lru_alloc_binrd_if #(parameter int SUBJECT_COUNT_LOG2 = 1);
  localparam int P_COUNT = 1 << SUBJECT_COUNT_LOG2;
  logic alloc_valid, alloc_ready, resp_valid, resp_ready, fill_done, hit_valid, inv_en, lru_wen, busy;
  logic [SUBJECT_COUNT_LOG2-1:0] resp_addr, hit_addr, inv_addr, lru_waddr, lru_qaddr;
  logic [P_COUNT-1:0] lru_dvalid;
  modport slave (
    input alloc_valid, resp_ready, fill_done, hit_valid, hit_addr, inv_en, inv_addr, lru_qaddr,
    output alloc_ready, resp_valid, resp_addr, lru_waddr, lru_wen, lru_dvalid, busy
  );
  modport master (
    output alloc_valid, resp_ready, fill_done, hit_valid, hit_addr, inv_en, inv_addr, lru_qaddr,
    input alloc_ready, resp_valid, resp_addr, lru_waddr, lru_wen, lru_dvalid, busy
  );
endinterface

// File: rtl/common_pseudo_lru_alloc_binrd.sv
// common_pseudo_lru_alloc_binrd: pLRU victim allocation FSM, way-valid vector and write-port merge.
// COMMON_PSEUDO_LRU_ALLOC_HIT_BUFFER_EN adds a one-entry buffer for hits colliding with the allocation touch.
module common_pseudo_lru_alloc_binrd #(parameter int SUBJECT_COUNT_LOG2 = 1) (
  input logic clk,
  input logic reset,
  common_pseudo_lru_alloc_binrd_if.slave bus
);
  localparam int P_COUNT = 1 << SUBJECT_COUNT_LOG2;
  typedef enum logic [1:0] {IDLE, RESP, FILL, TOUCH} state_t;
  state_t state, state_nxt;
  logic [SUBJECT_COUNT_LOG2-1:0] victim;
  logic [P_COUNT-1:0] valid, valid_nxt;
  logic accept, touch;
  always_comb begin
    accept = state == IDLE && bus.alloc_valid;
    touch = state == TOUCH;
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = bus.alloc_valid ? RESP : IDLE;
      RESP: state_nxt = bus.resp_ready ? FILL : RESP;
      FILL: state_nxt = bus.fill_done ? TOUCH : FILL;
      default: state_nxt = IDLE;
    endcase
    valid_nxt = valid;
    if (accept) valid_nxt[bus.lru_qaddr] = 1'b0;
    if (bus.inv_en) valid_nxt[bus.inv_addr] = 1'b0;
    // touch set comes last so it wins over a same-cycle invalidate
    if (touch) valid_nxt[victim] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      victim <= '0;
    end else begin
      state <= state_nxt;
      valid <= valid_nxt;
      if (accept) victim <= bus.lru_qaddr;
    end
  end
  assign bus.alloc_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_addr = victim;
  assign bus.busy = state != IDLE;
  assign bus.lru_dvalid = valid;
`ifdef COMMON_PSEUDO_LRU_ALLOC_HIT_BUFFER_EN
  logic pend_valid;
  logic [SUBJECT_COUNT_LOG2-1:0] pend_addr;
  assign bus.lru_wen = !reset && (touch || pend_valid || bus.hit_valid);
  assign bus.lru_waddr = touch ? victim : pend_valid ? pend_addr : bus.hit_addr;
  // a hit is parked whenever the port is already claimed by the touch or an older parked hit
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr <= '0;
    end else begin
      pend_valid <= bus.hit_valid && (touch || pend_valid);
      if (bus.hit_valid) pend_addr <= bus.hit_addr;
    end
  end
`else
  assign bus.lru_wen = !reset && (touch || bus.hit_valid);
  assign bus.lru_waddr = touch ? victim : bus.hit_addr;
`endif
endmodule
